bf_program_loader: RTL and testbench
====================================

Name: bf_program_loader

Overview:
- Writer side of the core's program memory. Accepts program characters one at a time (switch byte plus key strobe), filters them to valid BF opcodes and writes them sequentially into program memory.
- Checks bracket balance, then writes a 0x00 terminator and raises done. done drives the core's PMInputDone.
- Sits between the board inputs and the core/program-memory write port.

Parameters:
- ADDR_WIDTH, 8, program memory address width; DEPTH = 2**ADDR_WIDTH.
- NEST_WIDTH, 6, width of the bracket-depth counter; depth saturates at 2**NEST_WIDTH-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- char_in  input  8  ASCII character to load.
- char_strobe  input  1  level input; its rising edge submits char_in.
- finish  input  1  level input; its rising edge ends the load.
- pm_addr  output  ADDR_WIDTH  program memory write address.
- pm_data  output  8  program memory write data.
- pm_we  output  1  one-cycle write enable.
- count  output  ADDR_WIDTH  number of opcodes stored (excludes terminator).
- nest_depth  output  NEST_WIDTH  current open-bracket depth.
- done  output  1  load complete and valid; connects to PMInputDone.
- error  output  1  load aborted.
- err_code  output  2  abort reason: 0 none, 1 overflow, 2 unmatched ']', 3 unclosed '[' or depth saturation.

Behaviour:
- Reset (async, active-high): state LOAD; all outputs 0; edge-detect registers cleared to 0. A strobe already held high at reset release does not submit.
- Edge detect: each of char_strobe and finish is registered once. A rising edge is seen at cycle N when the input is 1 at N and was 0 at N-1. Held levels never repeat.
- Valid opcodes: 0x2B '+', 0x2D '-', 0x3C '<', 0x3E '>', 0x5B '[', 0x5D ']', 0x2E '.', 0x2C ','. Any other character is dropped with no write and no state change.
- States: LOAD, TERM, DONE, ERROR.
- LOAD, valid opcode accepted at edge cycle N:
  - At N+1: pm_we=1, pm_addr=count (old value), pm_data=char. Also at N+1, count increments.
  - '[': nest_depth+1. If nest_depth is already at maximum, go to ERROR with err_code 3 and no write.
  - ']' with nest_depth=0: go to ERROR with err_code 2 and no write. Otherwise nest_depth-1.
  - Overflow: if count = DEPTH-1, the last slot is reserved for the terminator. Go to ERROR with err_code 1 and no write.
- LOAD, finish edge:
  - nest_depth != 0: go to ERROR with err_code 3.
  - Otherwise go to TERM.
- TERM (1 cycle): pm_we=1, pm_addr=count, pm_data=0x00. Next state DONE.
- DONE: done=1 and held. All further strobes and finish edges are ignored. pm_we=0.
- ERROR: error=1 and err_code held. All inputs ignored. Only reset leaves DONE or ERROR.
- Simultaneous char and finish edges in the same cycle: the character is processed first. The finish edge is latched as pending and evaluated the next cycle. If the character caused ERROR, the pending finish is discarded.
- An empty program is legal: finish with count=0 writes 0x00 at address 0, then done=1.
- pm_we is never high on two consecutive cycles except for a final opcode write followed by the TERM write.
- Reset mid-load returns to LOAD with count=0. Memory contents are not cleared.

Optional Feature:
- Macro BF_LOADER_FILTER_EN.
- Defined: non-opcode characters are dropped as described above.
- Undefined: every nonzero character is written, including comments. Bracket tracking and the overflow check still apply. char_in=0x00 is always dropped so it cannot forge a terminator.

Test Plan:
- Reset, then strobe '+' '[' '-' ']' and finish -> writes at addr0..3 of 0x2B, 0x5B, 0x2D, 0x5D. TERM writes 0x00 at addr4. count=4, done=1, nest_depth=0.
- Strobe 'a' (0x61) then '>' with FILTER_EN defined -> a single write of 0x3E at addr0 and count=1. With the macro undefined -> 0x61 at addr0, 0x3E at addr1.
- Strobe ']' first -> error=1, err_code=2, no pm_we pulse. Later strobes ignored.
- Strobe '[' then finish -> error=1, err_code=3, no terminator write.
- ADDR_WIDTH=2: strobe '+' four times -> first three written at addr0..2. Fourth gives error with err_code=1. Separately, 3 opcodes then finish -> 0x00 at addr3, done=1.
- Coverage of timing and reset corners:
  - char_strobe and finish rising in the same cycle with '.' -> 0x2E written, then TERM, then done.
  - char_strobe held high 20 cycles -> exactly one write.
  - reset asserted during LOAD -> outputs return to 0 asynchronously.

Source files
------------

// File: rtl/bf_program_loader.sv
// Program-memory writer: filters BF opcodes from a keyed character stream, checks bracket balance
// and appends a 0x00 terminator. Optional macro BF_LOADER_FILTER_EN drops non-opcode characters.
//
// state   | meaning
// S_LOAD  | accepting characters, tracking depth and count
// S_TERM  | writing the 0x00 terminator at address count
// S_DONE  | load complete, done held high
// S_ERROR | load aborted, error and err_code held
module bf_program_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int NEST_WIDTH = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            char_in,
   input  logic                  char_strobe,
   input  logic                  finish,
   output logic [ADDR_WIDTH-1:0] pm_addr,
   output logic [7:0]            pm_data,
   output logic                  pm_we,
   output logic [ADDR_WIDTH-1:0] count,
   output logic [NEST_WIDTH-1:0] nest_depth,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code
);

   typedef enum logic [1:0] {
      S_LOAD,
      S_TERM,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] COUNT_MAX = {ADDR_WIDTH{1'b1}};
   localparam logic [NEST_WIDTH-1:0] NEST_MAX  = {NEST_WIDTH{1'b1}};

   localparam logic [1:0] ERR_OVERFLOW = 2'd1;
   localparam logic [1:0] ERR_CLOSE    = 2'd2;
   localparam logic [1:0] ERR_OPEN     = 2'd3;

   state_t state;
   logic   strobe_q;
   logic   finish_q;
   logic   armed;
   logic   finish_pend;
   logic   strobe_edge;
   logic   finish_edge;
   logic   char_ok;
   logic   is_open;
   logic   is_close;

   function automatic logic is_opcode(input logic [7:0] c);
      case (c)
         8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: is_opcode = 1'b1;
         default:                                                 is_opcode = 1'b0;
      endcase
   endfunction

   // armed stays low for the first cycle after reset so a level already high at release never counts as an edge
   assign strobe_edge = armed & char_strobe & ~strobe_q;
   assign finish_edge = armed & finish & ~finish_q;
   assign is_open     = (char_in == 8'h5B);
   assign is_close    = (char_in == 8'h5D);

`ifdef BF_LOADER_FILTER_EN
   assign char_ok = is_opcode(char_in);
`else
   assign char_ok = (char_in != 8'h00);
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_LOAD;
         strobe_q    <= 1'b0;
         finish_q    <= 1'b0;
         armed       <= 1'b0;
         finish_pend <= 1'b0;
         pm_addr     <= '0;
         pm_data     <= 8'h00;
         pm_we       <= 1'b0;
         count       <= '0;
         nest_depth  <= '0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_code    <= 2'd0;
      end else begin
         armed    <= 1'b1;
         strobe_q <= char_strobe;
         finish_q <= finish;
         pm_we    <= 1'b0;
         case (state)
            S_LOAD: begin
               if (finish_pend) begin
                  finish_pend <= 1'b0;
                  if (nest_depth != '0) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     err_code <= ERR_OPEN;
                  end else begin
                     state   <= S_TERM;
                     pm_we   <= 1'b1;
                     pm_addr <= count;
                     pm_data <= 8'h00;
                  end
               end else if (strobe_edge && char_ok) begin
                  // last slot is kept free for the terminator
                  if (count == COUNT_MAX) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     err_code <= ERR_OVERFLOW;
                  end else if (is_close && nest_depth == '0) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     err_code <= ERR_CLOSE;
                  end else if (is_open && nest_depth == NEST_MAX) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     err_code <= ERR_OPEN;
                  end else begin
                     pm_we   <= 1'b1;
                     pm_addr <= count;
                     pm_data <= char_in;
                     count   <= count + 1'b1;
                     if (is_open)
                        nest_depth <= nest_depth + 1'b1;
                     else if (is_close)
                        nest_depth <= nest_depth - 1'b1;
                     if (finish_edge)
                        finish_pend <= 1'b1;
                  end
               end else if (finish_edge) begin
                  if (nest_depth != '0) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     err_code <= ERR_OPEN;
                  end else begin
                     state   <= S_TERM;
                     pm_we   <= 1'b1;
                     pm_addr <= count;
                     pm_data <= 8'h00;
                  end
               end
            end
            S_TERM: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_DONE: begin
               state <= S_DONE;
            end
            S_ERROR: begin
               state <= S_ERROR;
            end
            default: begin
               state <= S_ERROR;
               error <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bf_program_loader.sv
// Directed bench for bf_program_loader: default instance plus a 2-bit-address instance for overflow.
module tb_bf_program_loader;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] char_in = 8'h00;
   logic       char_strobe = 1'b0;
   logic       finish = 1'b0;

   logic [7:0] pm_addr;
   logic [7:0] pm_data;
   logic       pm_we;
   logic [7:0] count;
   logic [5:0] nest_depth;
   logic       done;
   logic       error;
   logic [1:0] err_code;

   logic [1:0] pm_addr_s;
   logic [7:0] pm_data_s;
   logic       pm_we_s;
   logic [1:0] count_s;
   logic [5:0] nest_depth_s;
   logic       done_s;
   logic       error_s;
   logic [1:0] err_code_s;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] wr_addr [0:1023];
   logic [7:0] wr_data [0:1023];
   int         wr_cyc  [0:1023];
   int         wr_cnt = 0;
   logic [1:0] wr_addr_s [0:1023];
   logic [7:0] wr_data_s [0:1023];
   int         wr_cnt_s = 0;
   int         base = 0;
   int         base_s = 0;

   bf_program_loader dut (
      .clock(clock), .reset(reset), .char_in(char_in), .char_strobe(char_strobe), .finish(finish),
      .pm_addr(pm_addr), .pm_data(pm_data), .pm_we(pm_we), .count(count), .nest_depth(nest_depth),
      .done(done), .error(error), .err_code(err_code)
   );

   bf_program_loader #(.ADDR_WIDTH(2), .NEST_WIDTH(6)) dut_s (
      .clock(clock), .reset(reset), .char_in(char_in), .char_strobe(char_strobe), .finish(finish),
      .pm_addr(pm_addr_s), .pm_data(pm_data_s), .pm_we(pm_we_s), .count(count_s),
      .nest_depth(nest_depth_s), .done(done_s), .error(error_s), .err_code(err_code_s)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc = cyc + 1;

   always @(negedge clock) begin
      if (pm_we && wr_cnt < 1024) begin
         wr_addr[wr_cnt] = pm_addr;
         wr_data[wr_cnt] = pm_data;
         wr_cyc[wr_cnt]  = cyc;
         wr_cnt = wr_cnt + 1;
      end
      if (pm_we_s && wr_cnt_s < 1024) begin
         wr_addr_s[wr_cnt_s] = pm_addr_s;
         wr_data_s[wr_cnt_s] = pm_data_s;
         wr_cnt_s = wr_cnt_s + 1;
      end
   end

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b1; char_strobe = 1'b0; finish = 1'b0; char_in = 8'h00;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      base = wr_cnt;
      base_s = wr_cnt_s;
   endtask

   task automatic send_char(input logic [7:0] c);
      char_in = c; char_strobe = 1'b1;
      @(posedge clock); #1 char_strobe = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic send_finish();
      finish = 1'b1;
      @(posedge clock); #1 finish = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic send_both(input logic [7:0] c);
      char_in = c; char_strobe = 1'b1; finish = 1'b1;
      @(posedge clock); #1 char_strobe = 1'b0; finish = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      @(posedge clock); #1 reset = 1'b1;
      #1;
      checks++; if ({pm_we, done, error, err_code} !== 5'b0) begin errors++;
         $display("FAIL reset_flags: got %b expected 00000", {pm_we, done, error, err_code}); end
      checks++; if (count !== 8'd0 || nest_depth !== 6'd0) begin errors++;
         $display("FAIL reset_count: got count=%0d nest=%0d expected 0 0", count, nest_depth); end
      do_reset();
   endtask

   task automatic test_basic();
      logic [7:0] exp_d [0:4];
      exp_d[0] = 8'h2B; exp_d[1] = 8'h5B; exp_d[2] = 8'h2D; exp_d[3] = 8'h5D; exp_d[4] = 8'h00;
      do_reset();
      send_char(8'h2B);
      send_char(8'h5B);
      checks++; if (nest_depth !== 6'd1) begin errors++;
         $display("FAIL basic_nest_open: got %0d expected 1", nest_depth); end
      send_char(8'h2D);
      send_char(8'h5D);
      send_finish();
      repeat (3) @(posedge clock); #1;
      checks++; if (wr_cnt - base !== 5) begin errors++;
         $display("FAIL basic_write_count: got %0d expected 5", wr_cnt - base); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (wr_addr[base+i] !== 8'(i) || wr_data[base+i] !== exp_d[i]) begin errors++;
            $display("FAIL basic_write%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                     i, wr_addr[base+i], wr_data[base+i], i, exp_d[i]); end
      end
      checks++; if (count !== 8'd4 || done !== 1'b1 || nest_depth !== 6'd0 || error !== 1'b0) begin errors++;
         $display("FAIL basic_final: got count=%0d done=%b nest=%0d error=%b expected 4 1 0 0",
                  count, done, nest_depth, error); end
      send_char(8'h2B);
      send_finish();
      repeat (2) @(posedge clock); #1;
      checks++; if (wr_cnt - base !== 5 || done !== 1'b1 || count !== 8'd4) begin errors++;
         $display("FAIL done_ignores: got writes=%0d done=%b count=%0d expected 5 1 4",
                  wr_cnt - base, done, count); end
   endtask

   task automatic test_filter();
      do_reset();
      send_char(8'h61);
      send_char(8'h3E);
      send_char(8'h00);
      repeat (2) @(posedge clock); #1;
`ifdef BF_LOADER_FILTER_EN
      checks++; if (wr_cnt - base !== 1 || count !== 8'd1) begin errors++;
         $display("FAIL filter_count: got writes=%0d count=%0d expected 1 1", wr_cnt - base, count); end
      checks++; if (wr_addr[base] !== 8'h00 || wr_data[base] !== 8'h3E) begin errors++;
         $display("FAIL filter_write0: got addr=%0h data=%0h expected 0 3e", wr_addr[base], wr_data[base]); end
`else
      checks++; if (wr_cnt - base !== 2 || count !== 8'd2) begin errors++;
         $display("FAIL nofilter_count: got writes=%0d count=%0d expected 2 2", wr_cnt - base, count); end
      checks++; if (wr_addr[base] !== 8'h00 || wr_data[base] !== 8'h61) begin errors++;
         $display("FAIL nofilter_write0: got addr=%0h data=%0h expected 0 61", wr_addr[base], wr_data[base]); end
      checks++; if (wr_addr[base+1] !== 8'h01 || wr_data[base+1] !== 8'h3E) begin errors++;
         $display("FAIL nofilter_write1: got addr=%0h data=%0h expected 1 3e",
                  wr_addr[base+1], wr_data[base+1]); end
`endif
   endtask

   task automatic test_unmatched_close();
      do_reset();
      send_char(8'h5D);
      checks++; if (error !== 1'b1 || err_code !== 2'd2 || wr_cnt - base !== 0) begin errors++;
         $display("FAIL unmatched_close: got error=%b code=%0d writes=%0d expected 1 2 0",
                  error, err_code, wr_cnt - base); end
      send_char(8'h2B);
      send_finish();
      repeat (2) @(posedge clock); #1;
      checks++; if (wr_cnt - base !== 0 || count !== 8'd0 || done !== 1'b0 || err_code !== 2'd2) begin errors++;
         $display("FAIL error_ignores: got writes=%0d count=%0d done=%b code=%0d expected 0 0 0 2",
                  wr_cnt - base, count, done, err_code); end
   endtask

   task automatic test_unclosed_open();
      do_reset();
      send_char(8'h5B);
      send_finish();
      repeat (2) @(posedge clock); #1;
      checks++; if (error !== 1'b1 || err_code !== 2'd3 || done !== 1'b0 || wr_cnt - base !== 1) begin errors++;
         $display("FAIL unclosed_open: got error=%b code=%0d done=%b writes=%0d expected 1 3 0 1",
                  error, err_code, done, wr_cnt - base); end
   endtask

   task automatic test_depth_saturation();
      do_reset();
      for (int i = 0; i < 64; i++) send_char(8'h5B);
      checks++; if (error !== 1'b1 || err_code !== 2'd3 || nest_depth !== 6'd63 || wr_cnt - base !== 63) begin
         errors++;
         $display("FAIL depth_sat: got error=%b code=%0d nest=%0d writes=%0d expected 1 3 63 63",
                  error, err_code, nest_depth, wr_cnt - base); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 4; i++) send_char(8'h2B);
      checks++; if (wr_cnt_s - base_s !== 3 || count_s !== 2'd3) begin errors++;
         $display("FAIL overflow_writes: got writes=%0d count=%0d expected 3 3", wr_cnt_s - base_s, count_s); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wr_addr_s[base_s+i] !== 2'(i) || wr_data_s[base_s+i] !== 8'h2B) begin errors++;
            $display("FAIL overflow_write%0d: got addr=%0d data=%0h expected %0d 2b",
                     i, wr_addr_s[base_s+i], wr_data_s[base_s+i], i); end
      end
      checks++; if (error_s !== 1'b1 || err_code_s !== 2'd1) begin errors++;
         $display("FAIL overflow_error: got error=%b code=%0d expected 1 1", error_s, err_code_s); end
      do_reset();
      for (int i = 0; i < 3; i++) send_char(8'h2B);
      send_finish();
      repeat (2) @(posedge clock); #1;
      checks++; if (wr_cnt_s - base_s !== 4 || wr_addr_s[base_s+3] !== 2'd3 || wr_data_s[base_s+3] !== 8'h00
                    || done_s !== 1'b1 || error_s !== 1'b0) begin errors++;
         $display("FAIL full_term: got writes=%0d addr=%0d data=%0h done=%b error=%b expected 4 3 0 1 0",
                  wr_cnt_s - base_s, wr_addr_s[base_s+3], wr_data_s[base_s+3], done_s, error_s); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      send_both(8'h2E);
      repeat (3) @(posedge clock); #1;
      checks++; if (wr_cnt - base !== 2 || wr_data[base] !== 8'h2E || wr_addr[base] !== 8'h00
                    || wr_data[base+1] !== 8'h00 || wr_addr[base+1] !== 8'h01) begin errors++;
         $display("FAIL simul_writes: got n=%0d w0=%0h@%0h w1=%0h@%0h expected 2 2e@0 0@1",
                  wr_cnt - base, wr_data[base], wr_addr[base], wr_data[base+1], wr_addr[base+1]); end
      checks++; if (wr_cyc[base+1] - wr_cyc[base] !== 1 || done !== 1'b1) begin errors++;
         $display("FAIL simul_timing: got gap=%0d done=%b expected 1 1",
                  wr_cyc[base+1] - wr_cyc[base], done); end
      do_reset();
      send_both(8'h5D);
      repeat (3) @(posedge clock); #1;
      checks++; if (wr_cnt - base !== 0 || err_code !== 2'd2 || done !== 1'b0) begin errors++;
         $display("FAIL simul_error: got writes=%0d code=%0d done=%b expected 0 2 0",
                  wr_cnt - base, err_code, done); end
   endtask

   task automatic test_held_strobe();
      do_reset();
      char_in = 8'h3E; char_strobe = 1'b1;
      repeat (20) @(posedge clock);
      #1 char_strobe = 1'b0;
      repeat (2) @(posedge clock); #1;
      checks++; if (wr_cnt - base !== 1 || count !== 8'd1) begin errors++;
         $display("FAIL held_strobe: got writes=%0d count=%0d expected 1 1", wr_cnt - base, count); end
   endtask

   task automatic test_strobe_at_reset();
      @(posedge clock); #1;
      reset = 1'b1; finish = 1'b0; char_in = 8'h2B; char_strobe = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      base = wr_cnt;
      repeat (5) @(posedge clock); #1;
      checks++; if (wr_cnt - base !== 0 || count !== 8'd0) begin errors++;
         $display("FAIL strobe_at_reset: got writes=%0d count=%0d expected 0 0", wr_cnt - base, count); end
      char_strobe = 1'b0;
      @(posedge clock); #1;
      send_char(8'h2B);
      checks++; if (wr_cnt - base !== 1 || count !== 8'd1) begin errors++;
         $display("FAIL strobe_after_reset: got writes=%0d count=%0d expected 1 1", wr_cnt - base, count); end
   endtask

   task automatic test_async_reset();
      do_reset();
      send_char(8'h2B);
      send_char(8'h5B);
      @(posedge clock);
      #3 reset = 1'b1;
      #1;
      checks++; if (count !== 8'd0 || nest_depth !== 6'd0 || pm_addr !== 8'd0 || pm_data !== 8'd0) begin errors++;
         $display("FAIL async_reset: got count=%0d nest=%0d addr=%0h data=%0h expected 0 0 0 0",
                  count, nest_depth, pm_addr, pm_data); end
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (2) @(posedge clock); #1;
      base = wr_cnt;
      send_char(8'h2D);
      checks++; if (wr_cnt - base !== 1 || wr_addr[base] !== 8'h00 || wr_data[base] !== 8'h2D) begin errors++;
         $display("FAIL reload_after_reset: got writes=%0d addr=%0h data=%0h expected 1 0 2d",
                  wr_cnt - base, wr_addr[base], wr_data[base]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_filter();
      test_unmatched_close();
      test_unclosed_open();
      test_depth_saturation();
      test_overflow();
      test_simultaneous();
      test_held_strobe();
      test_strobe_at_reset();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
